lookahead_multiport_ram: RTL and testbench

Parametrised successor to the single-port lookahead data RAMs used by the LCD and data-format adapters. Provides one write port with byte enables and NUM_RD_PORTS independent read ports, all on one clock, with one-cycle registered read latency. Each read port has same-cycle write lookahead, merged per byte. An optional clear-on-reset sweep and a runtime clear request zero the array while write backpressure is asserted.

---
 rtl/lookahead_multiport_ram_pkg.sv | 19 +
 rtl/lookahead_ram_rd_bank.sv | 63 ++++++
 rtl/lookahead_multiport_ram.sv | 103 ++++++++++
 tb/tb_lookahead_multiport_ram.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lookahead_multiport_ram_pkg.sv
// Shared definitions for the multi-port lookahead RAM: byte width, sweep FSM
// state type and a constant-evaluable ceil(log2) helper.
package lookahead_multiport_ram_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/lookahead_ram_rd_bank.sv
// One replicated array copy plus one read port: registered read, registered
// write snapshot and a per-byte combinational merge for same-edge writes.
module lookahead_ram_rd_bank
  import lookahead_multiport_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [ADDRESS_WIDTH-1:0]         wr_address,
  input  logic [DATA_WIDTH-1:0]            wr_writedata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_byteenable,
  input  logic [ADDRESS_WIDTH-1:0]         rd_address,
  output logic [DATA_WIDTH-1:0]            rd_readdata
);

  localparam int BE_W = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] bypass_data_q;
  logic [BE_W-1:0]       bypass_mask_q;
  logic                  hit_q;
  logic                  rd_in_range;

  assign rd_in_range = 32'(rd_address) < DEPTH;

  // wr_en is only ever raised for in-range addresses
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_byteenable[b]) mem[wr_address][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_writedata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q          <= '0;
      bypass_data_q <= '0;
      bypass_mask_q <= '0;
      hit_q         <= 1'b0;
    end else begin
      rd_q          <= rd_in_range ? mem[rd_address] : '0;
      bypass_data_q <= wr_writedata;
      bypass_mask_q <= wr_byteenable;
      hit_q         <= wr_en && (wr_address == rd_address);
    end
  end

  always_comb begin
    rd_readdata = rd_q;
    if (hit_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bypass_mask_q[b]) rd_readdata[b*BYTE_WIDTH +: BYTE_WIDTH] = bypass_data_q[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/lookahead_multiport_ram.sv
// Multi-port lookahead RAM: one byte-enabled write port shared by NUM_RD_PORTS
// replicated read banks, with a zero sweep after reset and on clear.
//
// state | meaning
// IDLE  | normal operation, user writes accepted, clear starts a sweep
// SWEEP | zero written to address=counter each cycle, user writes dropped
module lookahead_multiport_ram
  import lookahead_multiport_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int NUM_RD_PORTS   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  clear,
  input  logic [ADDRESS_WIDTH-1:0]              wr_address,
  input  logic [DATA_WIDTH-1:0]                 wr_writedata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      wr_byteenable,
  input  logic                                  wr_write,
  output logic                                  wr_waitrequest,
  input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_readdata
);

  localparam int BE_W  = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  sweep_state_e             state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     wait_q;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [BE_W-1:0]          mem_be;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 1'b1;
      if (CLEAR_ON_RESET != 0) begin
        state <= SWEEP;
        cnt   <= CNT_LAST;
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wait_q <= (state_nxt == SWEEP);
    end
  end

  // The sweep owns the shared write port; its zero write also feeds lookahead.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = wr_write && !wait_q && (32'(wr_address) < DEPTH);
    mem_addr  = wr_address;
    mem_wdata = wr_writedata;
    mem_be    = wr_byteenable;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          cnt_nxt   = CNT_LAST;
        end
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_addr  = ADDRESS_WIDTH'(cnt);
        mem_wdata = '0;
        mem_be    = '1;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_waitrequest = wait_q;

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    lookahead_ram_rd_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .DEPTH         (DEPTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_bank (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_en         (mem_we),
      .wr_address    (mem_addr),
      .wr_writedata  (mem_wdata),
      .wr_byteenable (mem_be),
      .rd_address    (rd_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
      .rd_readdata   (rd_readdata[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// Scoreboard bench: two RAM instances (DEPTH 16 and 10) share one stimulus
// stream; each has its own reference model feeding an expectation queue.
module tb_lookahead_multiport_ram;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int NP  = 2;
  localparam int BEW = DW / 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            wr_write = 1'b0;
  logic [AW-1:0]   wr_address = '0;
  logic [DW-1:0]   wr_writedata = '0;
  logic [BEW-1:0]  wr_byteenable = '0;
  logic [NP*AW-1:0] rd_address = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*DW-1:0] rd;
    logic             wreq;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int D = (g == 0) ? 16 : 10;

    logic [NP*DW-1:0] rd_readdata;
    logic             wr_waitrequest;

    lookahead_multiport_ram #(
      .DATA_WIDTH     (DW),
      .DEPTH          (D),
      .ADDRESS_WIDTH  (AW),
      .NUM_RD_PORTS   (NP),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (clear),
      .wr_address     (wr_address),
      .wr_writedata   (wr_writedata),
      .wr_byteenable  (wr_byteenable),
      .wr_write       (wr_write),
      .wr_waitrequest (wr_waitrequest),
      .rd_address     (rd_address),
      .rd_readdata    (rd_readdata)
    );

    logic [DW-1:0] mm [D];
    int            sweep_left = D;
    logic          exp_wait = 1'b1;
    exp_t          exp_q[$];

    // Reference model: what each read port must show after this edge.
    always @(posedge clk or negedge reset_n) begin
      exp_t          e;
      bit            we, idle;
      int            wa, ra;
      logic [DW-1:0] wd, data;
      logic [BEW-1:0] wbe;
      if (!reset_n) begin
        sweep_left = D;
        exp_wait   = 1'b1;
        exp_q.delete();
        e.rd   = '0;
        e.wreq = 1'b1;
        exp_q.push_back(e);
      end else begin
        idle = (sweep_left == 0);
        we = 0; wa = 0; wd = '0; wbe = '0;
        if (!idle) begin
          we = 1; wa = sweep_left - 1; wd = '0; wbe = '1;
          sweep_left--;
        end else if (wr_write && !exp_wait && int'(wr_address) < D) begin
          we = 1; wa = int'(wr_address); wd = wr_writedata; wbe = wr_byteenable;
        end
        if (idle && clear) sweep_left = D;
        for (int k = 0; k < NP; k++) begin
          ra   = int'(rd_address[k*AW +: AW]);
          data = '0;
          if (ra < D) begin
            data = mm[ra];
            if (we && wa == ra)
              for (int b = 0; b < BEW; b++)
                if (wbe[b]) data[b*8 +: 8] = wd[b*8 +: 8];
          end
          e.rd[k*DW +: DW] = data;
        end
        if (we)
          for (int b = 0; b < BEW; b++)
            if (wbe[b]) mm[wa][b*8 +: 8] = wd[b*8 +: 8];
        exp_wait = (sweep_left > 0);
        e.wreq   = exp_wait;
        exp_q.push_back(e);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NP; k++)
          chk($sformatf("d%0d_port%0d_rd", D, k), 64'(rd_readdata[k*DW +: DW]), 64'(e.rd[k*DW +: DW]));
        chk($sformatf("d%0d_waitrequest", D), 64'(wr_waitrequest), 64'(e.wreq));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input bit en, input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    wr_write      = en;
    wr_address    = AW'(a);
    wr_writedata  = d;
    wr_byteenable = be;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_address = {AW'(a1), AW'(a0)};
  endtask

  // Bounded count of waitrequest-high cycles on both instances after release.
  task automatic count_sweep(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (g_cfg[0].wr_waitrequest) c0++;
      if (g_cfg[1].wr_waitrequest) c1++;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    int c0, c1;
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    count_sweep(c0, c1);
    chk("sweep_len_d16", 64'(c0), 64'd16);
    chk("sweep_len_d10", 64'(c1), 64'd10);
    cyc();

    for (int i = 0; i < 16; i++) begin set_rd(i, 15 - i); cyc(); end

    set_wr(1, 3, 32'hDEADBEEF, 4'hF); cyc();
    set_wr(0, 0, '0, '0); set_rd(3, 3); cyc(); cyc();

    set_wr(1, 5, 32'h11223344, 4'hF); set_rd(6, 6); cyc();
    set_wr(1, 5, 32'hAABBCCDD, 4'b0101); set_rd(5, 6); cyc();
    set_wr(0, 0, '0, '0); cyc(); cyc();

    for (int i = 0; i < 16; i++) begin set_wr(1, i, $urandom, 4'hF); set_rd(i, 15 - i); cyc(); end
    clear = 1'b1; set_wr(1, 7, 32'h0BADF00D, 4'hF); set_rd(7, 7); cyc();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin set_wr(1, i % 16, $urandom, 4'hF); set_rd(i % 16, 15 - (i % 16)); cyc(); end
    set_wr(0, 0, '0, '0);
    for (int i = 0; i < 16; i++) begin set_rd(i, 15 - i); cyc(); end

    set_wr(1, 12, 32'hCAFE0012, 4'hF); set_rd(12, 9); cyc();
    set_wr(1, 9, 32'h99990009, 4'hF); set_rd(12, 9); cyc();
    set_wr(0, 0, '0, '0); set_rd(12, 9); cyc(); cyc();

    clear = 1'b1; cyc();
    clear = 1'b0; repeat (5) cyc();
    pulse_reset(2);
    count_sweep(c0, c1);
    chk("restart_len_d16", 64'(c0), 64'd16);
    chk("restart_len_d10", 64'(c1), 64'd10);

    for (int i = 0; i < 2000; i++) begin
      int a;
      a = int'($urandom_range(0, 15));
      set_wr($urandom_range(0, 9) < 6, a, $urandom, BEW'($urandom));
      if ($urandom_range(0, 1) == 1) set_rd(a, $urandom_range(0, 15));
      else set_rd($urandom_range(0, 15), ($urandom_range(0, 1) == 1) ? a : int'($urandom_range(0, 15)));
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 399) == 0) begin
        clear = 1'b0;
        pulse_reset(int'($urandom_range(1, 3)));
      end else begin
        cyc();
      end
    end
    clear = 1'b0;
    set_wr(0, 0, '0, '0);
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
